// File: rtl/mul2_vector_scorer.sv
// Exhaustive scorer for bit-sliced 2x2-bit multiplier candidates.
// Each 16-bit word holds one lane per operand pair (lane i: a = i[3:2], b = i[1:0]).
// The vectors are driven, the candidate's products are captured, and the correct bits
// are counted over PASSES passes. Each pass rotates every lane left by one more position.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  S_IDLE  | vectors zero, waiting for start
//  S_DRIVE | vectors held for CAND_LAT+1 cycles, product captured on last edge
//  S_COUNT | one captured word scored per cycle, order y0..y3
//  S_NEXT  | rotate vectors and golden left by one lane, advance pass
//  S_DONE  | one-cycle done pulse, results frozen until next start
module mul2_vector_scorer #(
    parameter int  PASSES   = 4,
    parameter int  CAND_LAT = 0,
    localparam int SCORE_W  = $clog2(64*PASSES+1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_done,
    output logic [15:0]        o_a1,
    output logic [15:0]        o_a0,
    output logic [15:0]        o_b1,
    output logic [15:0]        o_b0,
    input  logic [15:0]        i_y3,
    input  logic [15:0]        i_y2,
    input  logic [15:0]        i_y1,
    input  logic [15:0]        i_y0,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_perfect,
    output logic [3:0]         o_word_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_COUNT,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [SCORE_W-1:0] FULL_SCORE = SCORE_W'(64*PASSES);
    localparam logic [4:0]         LAST_PASS  = 5'(PASSES-1);
    localparam logic [15:0]        LAT_LOAD   = 16'(CAND_LAT);

    // Golden products of the unrotated vectors, index k = product bit yk
    localparam logic [3:0][15:0] GOLD_BASE = {16'h8000, 16'h4C00, 16'h6AC0, 16'hA0A0};

    state_t             r_state;
    logic [15:0]        r_lat;
    logic [1:0]         r_word;
    logic [4:0]         r_pass;
    logic [15:0]        r_a1, r_a0, r_b1, r_b0;
    logic [3:0][15:0]   r_gold;
    logic [3:0][15:0]   r_ycap;
    logic [SCORE_W-1:0] r_score;
    logic               r_perfect;
    logic [3:0]         r_word_err;
    logic               r_busy;
    logic               r_done;

    logic [15:0]        w_diff;
    logic [4:0]         w_match_cnt;
    logic [SCORE_W-1:0] w_score_nxt;

    function automatic logic [15:0] rotl1(input logic [15:0] x);
        return {x[14:0], x[15]};
    endfunction

    // Correct-bit count of the word currently being scored
    always_comb begin
        w_diff      = r_ycap[r_word] ^ r_gold[r_word];
        w_match_cnt = '0;
        for (int i = 0; i < 16; i++) begin
            w_match_cnt = w_match_cnt + {4'b0000, ~w_diff[i]};
        end
        w_score_nxt = r_score + SCORE_W'(w_match_cnt);
    end

    // Sequencing FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_lat      <= '0;
            r_word     <= '0;
            r_pass     <= '0;
            r_a1       <= '0;
            r_a0       <= '0;
            r_b1       <= '0;
            r_b0       <= '0;
            r_gold     <= '0;
            r_ycap     <= '0;
            r_score    <= '0;
            r_perfect  <= 1'b0;
            r_word_err <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a1       <= 16'hFF00;
                        r_a0       <= 16'hF0F0;
                        r_b1       <= 16'hCCCC;
                        r_b0       <= 16'hAAAA;
                        r_gold     <= GOLD_BASE;
                        r_score    <= '0;
                        r_perfect  <= 1'b0;
                        r_word_err <= '0;
                        r_pass     <= '0;
                        r_lat      <= LAT_LOAD;
                        r_busy     <= 1'b1;
                        r_state    <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (r_lat == '0) begin
                        r_ycap  <= {i_y3, i_y2, i_y1, i_y0};
                        r_word  <= '0;
                        r_state <= S_COUNT;
                    end else begin
                        r_lat <= r_lat - 16'd1;
                    end
                end
                S_COUNT: begin
                    r_score            <= w_score_nxt;
                    r_word_err[r_word] <= r_word_err[r_word] | (|w_diff);
                    if (r_word == 2'd3) begin
                        if (r_pass == LAST_PASS) begin
                            r_done    <= 1'b1;
                            r_busy    <= 1'b0;
                            r_perfect <= (w_score_nxt == FULL_SCORE);
                            r_a1      <= '0;
                            r_a0      <= '0;
                            r_b1      <= '0;
                            r_b0      <= '0;
                            r_state   <= S_DONE;
                        end else begin
                            r_state <= S_NEXT;
                        end
                    end else begin
                        r_word <= r_word + 2'd1;
                    end
                end
                S_NEXT: begin
                    r_a1 <= rotl1(r_a1);
                    r_a0 <= rotl1(r_a0);
                    r_b1 <= rotl1(r_b1);
                    r_b0 <= rotl1(r_b0);
                    for (int k = 0; k < 4; k++) begin
                        r_gold[k] <= rotl1(r_gold[k]);
                    end
                    r_pass  <= r_pass + 5'd1;
                    r_lat   <= LAT_LOAD;
                    r_state <= S_DRIVE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_a1       = r_a1;
    assign o_a0       = r_a0;
    assign o_b1       = r_b1;
    assign o_b0       = r_b0;
    assign o_score    = r_score;
    assign o_perfect  = r_perfect;
    assign o_word_err = r_word_err;

endmodule

// File: tb/tb_mul2_vector_scorer.sv
// Directed bench: two scorers (combinational and 2-cycle candidate latency) driving
// behavioural multiplier candidates built from the operand slices.
module tb_mul2_vector_scorer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start0, start2;
    int   mode;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [15:0] a1_0, a0_0, b1_0, b0_0, a1_2, a0_2, b1_2, b0_2;
    logic [63:0] cand0, cand2, ideal0;
    logic [63:0] p0_s1 = '0, p0_s2 = '0, p2_s1 = '0, p2_s2 = '0;
    logic        busy0, done0, perf0, busy2, done2, perf2;
    logic [8:0]  score0, score2;
    logic [3:0]  werr0, werr2;

    mul2_vector_scorer #(.PASSES(4), .CAND_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_start(start0), .o_busy(busy0), .o_done(done0),
        .o_a1(a1_0), .o_a0(a0_0), .o_b1(b1_0), .o_b0(b0_0),
        .i_y3(cand0[63:48]), .i_y2(cand0[47:32]), .i_y1(cand0[31:16]), .i_y0(cand0[15:0]),
        .o_score(score0), .o_perfect(perf0), .o_word_err(werr0)
    );

    mul2_vector_scorer #(.PASSES(4), .CAND_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_start(start2), .o_busy(busy2), .o_done(done2),
        .o_a1(a1_2), .o_a0(a0_2), .o_b1(b1_2), .o_b0(b0_2),
        .i_y3(cand2[63:48]), .i_y2(cand2[47:32]), .i_y1(cand2[31:16]), .i_y0(cand2[15:0]),
        .o_score(score2), .o_perfect(perf2), .o_word_err(werr2)
    );

    // Lane-wise 2x2 multiply, returns {y3,y2,y1,y0}
    function automatic logic [63:0] mult(input logic [15:0] a1, input logic [15:0] a0,
                                         input logic [15:0] b1, input logic [15:0] b0);
        logic [15:0] y3, y2, y1, y0;
        logic [3:0]  p;
        y3 = '0; y2 = '0; y1 = '0; y0 = '0;
        for (int i = 0; i < 16; i++) begin
            p = {2'b00, a1[i], a0[i]} * {2'b00, b1[i], b0[i]};
            y3[i] = p[3]; y2[i] = p[2]; y1[i] = p[1]; y0[i] = p[0];
        end
        return {y3, y2, y1, y0};
    endfunction

    always_comb begin
        ideal0 = mult(a1_0, a0_0, b1_0, b0_0);
        case (mode)
            1:       cand0 = '0;
            2:       cand0 = ~ideal0;
            3:       cand0 = ideal0 ^ 64'h1;
            4:       cand0 = p0_s2;
            default: cand0 = ideal0;
        endcase
        cand2 = p2_s2;
    end

    always @(posedge clk) begin
        p0_s1 <= mult(a1_0, a0_0, b1_0, b0_0);
        p0_s2 <= p0_s1;
        p2_s1 <= mult(a1_2, a0_2, b1_2, b0_2);
        p2_s2 <= p2_s1;
    end

    // Starts a run (edge 0 samples start), optionally re-pulses start at edges re1/re2,
    // and observes 60 edges.
    task automatic run_dut(input int sel, input int re1, input int re2,
                           output int done_edge, output int ndone,
                           output logic [63:0] v0, output logic [63:0] v6,
                           output logic busy_e0, output logic busy_at_done);
        logic d, b;
        done_edge = -1; ndone = 0; v0 = '0; v6 = '0; busy_e0 = 1'b0; busy_at_done = 1'b1;
        @(posedge clk); #1;
        if (sel == 0) start0 = 1'b1; else start2 = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            start0 = 1'b0; start2 = 1'b0;
            if (n + 1 == re1 || n + 1 == re2) begin
                if (sel == 0) start0 = 1'b1; else start2 = 1'b1;
            end
            d = (sel == 0) ? done0 : done2;
            b = (sel == 0) ? busy0 : busy2;
            if (n == 0) begin
                busy_e0 = b;
                v0 = (sel == 0) ? {a1_0, a0_0, b1_0, b0_0} : {a1_2, a0_2, b1_2, b0_2};
            end
            if (n == 6) v6 = (sel == 0) ? {a1_0, a0_0, b1_0, b0_0} : {a1_2, a0_2, b1_2, b0_2};
            if (d) begin
                if (done_edge < 0) begin
                    done_edge    = n;
                    busy_at_done = b;
                end
                ndone++;
            end
        end
    endtask

    task automatic test_reset;
        n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy0); end
        n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done0); end
        n_cmp++; if (score0 !== 9'd0) begin n_err++; $display("FAIL reset_score: got %0d want 0", score0); end
        n_cmp++; if (perf0 !== 1'b0 || werr0 !== 4'b0) begin n_err++; $display("FAIL reset_flags: got perfect=%b werr=%b want 0/0000", perf0, werr0); end
        n_cmp++; if ({a1_0, a0_0, b1_0, b0_0} !== 64'h0) begin n_err++; $display("FAIL reset_vectors: got %h want 0", {a1_0, a0_0, b1_0, b0_0}); end
    endtask

    task automatic test_ideal;
        int de, nd; logic [63:0] v0, v6; logic be0, bd;
        mode = 0;
        run_dut(0, -1, -1, de, nd, v0, v6, be0, bd);
        n_cmp++; if (de !== 23) begin n_err++; $display("FAIL ideal_done_edge: got %0d want 23", de); end
        n_cmp++; if (nd !== 1) begin n_err++; $display("FAIL ideal_done_count: got %0d want 1", nd); end
        n_cmp++; if (score0 !== 9'd256) begin n_err++; $display("FAIL ideal_score: got %0d want 256", score0); end
        n_cmp++; if (perf0 !== 1'b1) begin n_err++; $display("FAIL ideal_perfect: got %b want 1", perf0); end
        n_cmp++; if (werr0 !== 4'b0000) begin n_err++; $display("FAIL ideal_werr: got %b want 0000", werr0); end
        n_cmp++; if (be0 !== 1'b1 || bd !== 1'b0) begin n_err++; $display("FAIL ideal_busy: got e0=%b done=%b want 1/0", be0, bd); end
        n_cmp++; if (v0 !== 64'hFF00_F0F0_CCCC_AAAA) begin n_err++; $display("FAIL ideal_vec_pass0: got %h want ff00f0f0ccccaaaa", v0); end
        n_cmp++; if (v6 !== 64'hFE01_E1E1_9999_5555) begin n_err++; $display("FAIL ideal_vec_pass1: got %h want fe01e1e199995555", v6); end
        n_cmp++; if ({a1_0, a0_0, b1_0, b0_0} !== 64'h0) begin n_err++; $display("FAIL ideal_vec_idle: got %h want 0", {a1_0, a0_0, b1_0, b0_0}); end
    endtask

    task automatic test_zero;
        int de, nd; logic [63:0] v0, v6; logic be0, bd;
        mode = 1;
        run_dut(0, -1, -1, de, nd, v0, v6, be0, bd);
        n_cmp++; if (score0 !== 9'd200) begin n_err++; $display("FAIL zero_score: got %0d want 200", score0); end
        n_cmp++; if (perf0 !== 1'b0) begin n_err++; $display("FAIL zero_perfect: got %b want 0", perf0); end
        n_cmp++; if (werr0 !== 4'b1111) begin n_err++; $display("FAIL zero_werr: got %b want 1111", werr0); end
    endtask

    task automatic test_invert_flip;
        int de, nd; logic [63:0] v0, v6; logic be0, bd;
        mode = 2;
        run_dut(0, -1, -1, de, nd, v0, v6, be0, bd);
        n_cmp++; if (score0 !== 9'd0) begin n_err++; $display("FAIL invert_score: got %0d want 0", score0); end
        n_cmp++; if (werr0 !== 4'b1111) begin n_err++; $display("FAIL invert_werr: got %b want 1111", werr0); end
        mode = 3;
        run_dut(0, -1, -1, de, nd, v0, v6, be0, bd);
        n_cmp++; if (score0 !== 9'd252) begin n_err++; $display("FAIL flip_score: got %0d want 252", score0); end
        n_cmp++; if (werr0 !== 4'b0001) begin n_err++; $display("FAIL flip_werr: got %b want 0001", werr0); end
        n_cmp++; if (perf0 !== 1'b0) begin n_err++; $display("FAIL flip_perfect: got %b want 0", perf0); end
    endtask

    task automatic test_latency;
        int de, nd; logic [63:0] v0, v6; logic be0, bd;
        run_dut(2, -1, -1, de, nd, v0, v6, be0, bd);
        n_cmp++; if (de !== 31) begin n_err++; $display("FAIL lat2_done_edge: got %0d want 31", de); end
        n_cmp++; if (score2 !== 9'd256) begin n_err++; $display("FAIL lat2_score: got %0d want 256", score2); end
        n_cmp++; if (perf2 !== 1'b1 || werr2 !== 4'b0) begin n_err++; $display("FAIL lat2_flags: got perfect=%b werr=%b want 1/0000", perf2, werr2); end
        mode = 4;
        run_dut(0, -1, -1, de, nd, v0, v6, be0, bd);
        n_cmp++; if (!(score0 < 9'd256)) begin n_err++; $display("FAIL lat_mismatch_score: got %0d want below 256", score0); end
        n_cmp++; if (perf0 !== 1'b0) begin n_err++; $display("FAIL lat_mismatch_perfect: got %b want 0", perf0); end
    endtask

    task automatic test_back_to_back;
        int de, nd; logic [63:0] v0, v6; logic be0, bd;
        mode = 0;
        run_dut(0, 3, 10, de, nd, v0, v6, be0, bd);
        n_cmp++; if (nd !== 1) begin n_err++; $display("FAIL restart_done_count: got %0d want 1", nd); end
        n_cmp++; if (de !== 23) begin n_err++; $display("FAIL restart_done_edge: got %0d want 23", de); end
        n_cmp++; if (score0 !== 9'd256 || perf0 !== 1'b1) begin n_err++; $display("FAIL restart_score: got %0d/%b want 256/1", score0, perf0); end
    endtask

    task automatic test_reset_abort;
        int de, nd, seen; logic [63:0] v0, v6; logic be0, bd;
        mode = 0;
        @(posedge clk); #1;
        start0 = 1'b1;
        for (int n = 0; n <= 14; n++) begin
            @(posedge clk); #1;
            start0 = 1'b0;
        end
        n_cmp++; if (score0 === 9'd0) begin n_err++; $display("FAIL abort_pre_score: got %0d want nonzero", score0); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin n_err++; $display("FAIL abort_busy_done: got %b/%b want 0/0", busy0, done0); end
        n_cmp++; if (score0 !== 9'd0) begin n_err++; $display("FAIL abort_score: got %0d want 0", score0); end
        n_cmp++; if ({a1_0, a0_0, b1_0, b0_0} !== 64'h0) begin n_err++; $display("FAIL abort_vectors: got %h want 0", {a1_0, a0_0, b1_0, b0_0}); end
        seen = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (done0) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
        run_dut(0, -1, -1, de, nd, v0, v6, be0, bd);
        n_cmp++; if (de !== 23 || nd !== 1) begin n_err++; $display("FAIL abort_rerun_done: got edge %0d count %0d want 23/1", de, nd); end
        n_cmp++; if (score0 !== 9'd256 || perf0 !== 1'b1) begin n_err++; $display("FAIL abort_rerun_score: got %0d/%b want 256/1", score0, perf0); end
    endtask

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0;
        start2 = 1'b0;
        mode   = 0;
        #12;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        test_ideal;
        test_zero;
        test_invert_flip;
        test_latency;
        test_back_to_back;
        test_reset_abort;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
